// File: rtl/serial_frame_tx_if.sv
// Bundles the RB1 read port and the sen/sd serial link of serial_frame_tx.
// The master side is the transmitter; the slave side is the register bank plus receiver.
interface serial_frame_tx_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 18
);
    logic              S1_done;
    logic              RB1_RW;
    logic [ADDR_W-1:0] RB1_A;
    logic [DATA_W-1:0] RB1_Q;
    logic              sen;
    logic              sd;

    modport master (
        output S1_done,
        output RB1_RW,
        output RB1_A,
        input  RB1_Q,
        output sen,
        output sd
    );

    modport slave (
        input  S1_done,
        input  RB1_RW,
        input  RB1_A,
        output RB1_Q,
        input  sen,
        input  sd
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Reads NUM_WORDS words from RB1 and sends each as one {addr, data} frame on sen/sd, once per reset.
// Define TX_PARITY_EN to append an even-parity bit over address and data to every frame.
module serial_frame_tx #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 18,
    parameter int NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_tx_if.master bus
);

`ifdef TX_PARITY_EN
    localparam int FL = ADDR_W + DATA_W + 1;
`else
    localparam int FL = ADDR_W + DATA_W;
`endif
    localparam int                CNT_W     = $clog2(FL);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FL - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [FL-1:0]     shift_q,    shift_d;
    logic [ADDR_W-1:0] rb1_a_q,    rb1_a_d;
    logic              sen_q,      sen_d;
    logic              sd_q,       sd_d;
    logic              done_q,     done_d;
    logic [FL-1:0]     frame;

    always_comb begin
`ifdef TX_PARITY_EN
        frame = {rb1_a_q, bus.RB1_Q, ^{rb1_a_q, bus.RB1_Q}};
`else
        frame = {rb1_a_q, bus.RB1_Q};
`endif
    end

    // Outputs are registered, so each state computes what the pins show in the following cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rb1_a_d    = rb1_a_q;
        sen_d      = 1'b1;
        sd_d       = 1'b0;
        done_d     = done_q;

        case (state_q)
            ST_FETCH: begin
                rb1_a_d = word_cnt_q;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = frame;
                bit_cnt_d = '0;
                sen_d     = 1'b0;
                sd_d      = frame[FL-1];
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (word_cnt_q < LAST_WORD) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    shift_d   = shift_q << 1;
                    sen_d     = 1'b0;
                    sd_d      = shift_d[FL-1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                done_d = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rb1_a_q    <= '0;
            sen_q      <= 1'b1;
            sd_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rb1_a_q    <= rb1_a_d;
            sen_q      <= sen_d;
            sd_q       <= sd_d;
            done_q     <= done_d;
        end
    end

    // The bank is only ever read, so the select is tied rather than held in a flop.
    assign bus.RB1_RW  = 1'b1;
    assign bus.RB1_A   = rb1_a_q;
    assign bus.sen     = sen_q;
    assign bus.sd      = sd_q;
    assign bus.S1_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized scoreboard bench for serial_frame_tx: a receiver model decodes sen/sd frames
// and compares them with the words queued from the bench's copy of RB1.
module tb_serial_frame_tx;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 18;
    localparam int NUM_WORDS = 8;
`ifdef TX_PARITY_EN
    localparam int FL = ADDR_W + DATA_W + 1;
`else
    localparam int FL = ADDR_W + DATA_W;
`endif
    localparam int PERIOD   = FL + 2;
    localparam int DONE_CYC = NUM_WORDS * PERIOD;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic [DATA_W-1:0] mem [NUM_WORDS];
    logic [DATA_W-1:0] noise;
    exp_t exp_q [$];
    int total;
    int bad;

    serial_frame_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    serial_frame_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data follows the address while idle and is garbage while a frame is on the wire.
    always @(negedge clk) noise = DATA_W'($urandom);
    assign bus.RB1_Q = bus.sen ? mem[bus.RB1_A] : noise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic load_expected();
        exp_t e;
        for (int i = 0; i < NUM_WORDS; i++) begin
            e.addr = ADDR_W'(i);
            e.data = mem[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = DATA_W'($urandom);
    endtask

    // Receiver model and timing monitor, sampled on the falling edge.
    int cyc;
    int nbits;
    int frame_idx;
    logic [FL-1:0] fr;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc       = 0;
            nbits     = 0;
            frame_idx = 0;
        end else begin
            check("rb1_rw", 32'(bus.RB1_RW), 32'd1);
            check("s1_done", 32'(bus.S1_done), 32'(cyc >= DONE_CYC));
            if (!bus.sen) begin
                if (nbits == 0) check("frame_start_cycle", 32'(cyc), 32'(2 + frame_idx * PERIOD));
                fr = {fr[FL-2:0], bus.sd};
                nbits++;
            end else begin
                check("sd_idle", 32'(bus.sd), 32'd0);
                if (nbits != 0) begin
                    check("frame_len", 32'(nbits), 32'(FL));
                    if (exp_q.size() == 0) begin
                        check("spurious_frame_queue", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
`ifdef TX_PARITY_EN
                        check("frame_addr", 32'(fr[FL-1 -: ADDR_W]), 32'(e.addr));
                        check("frame_data", 32'(fr[DATA_W:1]), 32'(e.data));
                        check("frame_parity", 32'(fr[0]),
                              32'(($countones(e.addr) + $countones(e.data)) % 2));
`else
                        check("frame_addr", 32'(fr[FL-1 -: ADDR_W]), 32'(e.addr));
                        check("frame_data", 32'(fr[DATA_W-1:0]), 32'(e.data));
`endif
                    end
                    frame_idx++;
                    nbits = 0;
                end
            end
            cyc++;
        end
    end

    task automatic do_run(input bit mid_rst);
        rst = 1'b1;
        exp_q.delete();
        load_expected();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        if (mid_rst) begin
            // Land on frame 3, bit 10, then hit reset while sen is low.
            repeat (2 + 3 * PERIOD + 10 + 1) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("mid_rst_sen", 32'(bus.sen), 32'd1);
            check("mid_rst_rb1_a", 32'(bus.RB1_A), 32'd0);
            check("mid_rst_sd", 32'(bus.sd), 32'd0);
            check("mid_rst_done", 32'(bus.S1_done), 32'd0);
            exp_q.delete();
            load_expected();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
        repeat (DONE_CYC + 2 * PERIOD) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_sen", 32'(bus.sen), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s1_done", 32'(bus.S1_done), 32'd0);
        check("reset_rb1_rw", 32'(bus.RB1_RW), 32'd1);
        check("reset_rb1_a", 32'(bus.RB1_A), 32'd0);
        check("reset_sen", 32'(bus.sen), 32'd1);
        check("reset_sd", 32'(bus.sd), 32'd0);

        randomize_mem();
        mem[0] = 18'h2AAAA;
        do_run(1'b0);

        for (int i = 0; i < NUM_WORDS; i++) mem[i] = DATA_W'(18'h01234 + i);
        do_run(1'b0);

        randomize_mem();
        mem[7] = 18'h3FFFF;
        mem[6] = 18'h00000;
        do_run(1'b0);

        randomize_mem();
        mem[0] = 18'h00001;
        do_run(1'b1);

        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            do_run(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
